alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the pipeline's ALU.
- Decodes a fetched RV32I instruction into the 4-bit ALU control code, selects the ALU operands, and registers them with a valid/ready handshake toward EX.
- Honours downstream stall and branch flush.
- Latches a HALT state on an illegal or unsupported instruction.

Parameters:
- XLEN, 32, datapath width for PC, register data and operands.
- CTRL_W, 4, width of the ALU control code.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode-side instruction valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- pc  in  XLEN  PC of instr.
- rs1_data  in  XLEN  register file read port 1.
- rs2_data  in  XLEN  register file read port 2.
- flush  in  1  branch redirect; kill held and incoming ops.
- out_valid  out  1  EX operands valid.
- out_ready  in  1  EX accepts.
- alu_in1  out  XLEN  ALU operand 1.
- alu_in2  out  XLEN  ALU operand 2.
- alu_ctrl  out  CTRL_W  ALU control code.
- alu_pc  out  XLEN  registered PC.
- rd_addr  out  5  destination register (0 for branches and stores).
- illegal  out  1  high while in HALT.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_in1/alu_in2/alu_pc=0, alu_ctrl=0, rd_addr=0, illegal=0, state=RUN.
- Handshake: in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; outputs update on the next edge, so latency is 1 cycle.
  - Held outputs must not change while out_valid && !out_ready.
  - out_valid drops after out_ready if nothing new is accepted.
- Control code map:
  - 0 ADD: ADD, ADDI, LOAD, STORE, LUI, AUIPC.
  - 1 SUB, 2 XOR/XORI, 3 OR/ORI, 4 AND/ANDI, 5 SLL/SLLI, 6 SRL/SRLI.
  - 7 BEQ, 8 BNE.
  - 9 SLT/SLTI/SLTU/SLTIU.
  - A SRA/SRAI.
  - B reserved, never emitted.
- Operands:
  - R-type and branch: in1=rs1_data, in2=rs2_data.
  - I-type and LOAD: in2 = sign-extended imm[11:0].
  - Shift-immediate: in2 = zero-extended shamt[4:0].
  - STORE: in2 = sign-extended S-immediate.
  - LUI: in1=0, in2={instr[31:12],12'b0}.
  - AUIPC: in1=pc, in2={instr[31:12],12'b0}.
- Illegal: unknown opcode, branch funct3 other than BEQ/BNE, bad funct7 (only 0x00, or 0x20 for SUB/SRA/SRAI), or instr==0.
  - An accepted illegal instruction is not issued (out_valid stays 0 for it).
  - State goes to HALT; illegal=1 from the next cycle.
- FSM: RUN->HALT on an accepted illegal instruction; HALT->RUN on flush; HALT ignores in_valid.
- flush: on the next edge out_valid=0; any same-cycle input is dropped (in_ready=0 that cycle). Flush takes priority over accept and over out_ready.
- Mid-operation reset clears everything immediately, regardless of clock.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined:
  - Adds outputs perf_issued[31:0] (count of EX handshakes, out_valid&&out_ready) and perf_stall[31:0] (cycles with out_valid&&!out_ready).
  - Both reset to 0, wrap at 2^32, hold during HALT, and are not cleared by flush.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ctrl=0, in1=5, in2=7, rd=3.
- ADDI x1,x0,-1 (0xFFF00093) -> ctrl=0, in2=0xFFFFFFFF; SRAI x1,x1,3 (0x4030D093) -> ctrl=0xA, in2=3; SUB (0x402081B3) -> ctrl=1.
- BEQ (0x00208463) with out_ready=0 for 3 cycles -> ctrl=7, outputs stable, in_ready=0 until out_ready=1; then a second op accepted the same cycle.
- AUIPC x5,0x12345 (0x12345297), pc=0x100 -> ctrl=0, in1=0x100, in2=0x12345000.
- instr=0x00000000 accepted -> no issue, illegal=1 next cycle, in_ready=0; flush pulse -> illegal=0, RUN, next ADD accepted.
- flush asserted with out_valid=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, input dropped; rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I ID/EX issue stage: decodes to an ALU control code, selects operands and registers them
// behind a valid/ready handshake. Define ALU_ISSUE_PERF_EN to add issue/stall perf counters.
module alu_issue_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_in1,
   output logic [XLEN-1:0]   alu_in2,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [XLEN-1:0]   alu_pc,
   output logic [4:0]        rd_addr,
   output logic              illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall
`endif
);

   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [CTRL_W-1:0] CtrlAdd = CTRL_W'(4'h0);
   localparam logic [CTRL_W-1:0] CtrlSub = CTRL_W'(4'h1);
   localparam logic [CTRL_W-1:0] CtrlXor = CTRL_W'(4'h2);
   localparam logic [CTRL_W-1:0] CtrlOr  = CTRL_W'(4'h3);
   localparam logic [CTRL_W-1:0] CtrlAnd = CTRL_W'(4'h4);
   localparam logic [CTRL_W-1:0] CtrlSll = CTRL_W'(4'h5);
   localparam logic [CTRL_W-1:0] CtrlSrl = CTRL_W'(4'h6);
   localparam logic [CTRL_W-1:0] CtrlBeq = CTRL_W'(4'h7);
   localparam logic [CTRL_W-1:0] CtrlBne = CTRL_W'(4'h8);
   localparam logic [CTRL_W-1:0] CtrlSlt = CTRL_W'(4'h9);
   localparam logic [CTRL_W-1:0] CtrlSra = CTRL_W'(4'hA);

   typedef enum logic {StRun, StHalt} state_e;
   state_e state_q, state_d;

   logic [6:0]        opcode, funct7;
   logic [2:0]        funct3;
   logic [XLEN-1:0]   imm_i, imm_s, imm_u, shamt;
   logic [CTRL_W-1:0] f3_ctrl, dec_ctrl;
   logic [XLEN-1:0]   dec_in1, dec_in2;
   logic [4:0]        dec_rd;
   logic              dec_illegal;
   logic              accept;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = XLEN'($signed(instr[31:20]));
   assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
   assign shamt  = XLEN'(instr[24:20]);

   // funct3 picks the operation for both OP and OP-IMM; funct7 only selects SUB/SRA
   always_comb begin
      case (funct3)
         3'b000:  f3_ctrl = CtrlAdd;
         3'b001:  f3_ctrl = CtrlSll;
         3'b010:  f3_ctrl = CtrlSlt;
         3'b011:  f3_ctrl = CtrlSlt;
         3'b100:  f3_ctrl = CtrlXor;
         3'b101:  f3_ctrl = CtrlSrl;
         3'b110:  f3_ctrl = CtrlOr;
         default: f3_ctrl = CtrlAnd;
      endcase
   end

   always_comb begin
      dec_ctrl    = f3_ctrl;
      dec_in1     = rs1_data;
      dec_in2     = rs2_data;
      dec_rd      = instr[11:7];
      dec_illegal = 1'b0;
      case (opcode)
         OpReg: begin
            if (funct7 == 7'h20 && funct3 == 3'b000) dec_ctrl = CtrlSub;
            else if (funct7 == 7'h20 && funct3 == 3'b101) dec_ctrl = CtrlSra;
            else if (funct7 != 7'h00) dec_illegal = 1'b1;
         end
         OpImm: begin
            dec_in2 = imm_i;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_in2 = shamt;
               if (funct3 == 3'b101 && funct7 == 7'h20) dec_ctrl = CtrlSra;
               else if (funct7 != 7'h00) dec_illegal = 1'b1;
            end
         end
         OpLoad: begin
            dec_ctrl = CtrlAdd;
            dec_in2  = imm_i;
         end
         OpStore: begin
            dec_ctrl = CtrlAdd;
            dec_in2  = imm_s;
            dec_rd   = 5'd0;
         end
         OpLui: begin
            dec_ctrl = CtrlAdd;
            dec_in1  = '0;
            dec_in2  = imm_u;
         end
         OpAuipc: begin
            dec_ctrl = CtrlAdd;
            dec_in1  = pc;
            dec_in2  = imm_u;
         end
         OpBranch: begin
            dec_rd = 5'd0;
            if (funct3 == 3'b000) dec_ctrl = CtrlBeq;
            else if (funct3 == 3'b001) dec_ctrl = CtrlBne;
            else dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (instr == 32'd0) dec_illegal = 1'b1;
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StRun;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:   if (accept && dec_illegal) state_d = StHalt;
         StHalt:  if (flush) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      illegal  = (state_q == StHalt);
      in_ready = (state_q == StRun) && !flush && (!out_valid || out_ready);
   end

   // Payload only loads on a legal accept, so it holds through any stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_in1   <= '0;
         alu_in2   <= '0;
         alu_ctrl  <= '0;
         alu_pc    <= '0;
         rd_addr   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= !dec_illegal;
         if (!dec_illegal) begin
            alu_in1  <= dec_in1;
            alu_in2  <= dec_in2;
            alu_ctrl <= dec_ctrl;
            alu_pc   <= pc;
            rd_addr  <= dec_rd;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (out_valid && out_ready)  perf_issued <= perf_issued + 32'd1;
         if (out_valid && !out_ready) perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
